counter_irq_ctrl: RTL
=====================

Name: counter_irq_ctrl

Overview:
- Sits directly downstream of the ALU counter block and consumes its exported counter_result / counter_addition pair.
- Detects the "auto-run reached stop value" flag and raises a core interrupt request using a 4-phase req/ack handshake.
- Snapshots the counter value at the event and counts events lost while an earlier request is outstanding.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (8), width of the counter data path.
- MISS_WIDTH, 4, width of the saturating missed-event counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- counter_result  input  DATA_WIDTH  counter value from the counter block; 0 when not exported
- counter_addition  input  DATA_WIDTH  {7'h01, reach_flag} when exported, else 0
- irq_en  input  1  interrupt enable from the control register
- irq_ack  input  1  core acknowledge (4-phase)
- miss_clr  input  1  synchronous clear of miss_count
- irq_req  output  1  interrupt request to the core
- irq_vector  output  DATA_WIDTH  counter_result captured at the accepted event
- miss_count  output  MISS_WIDTH  events dropped while busy; saturating
- irq_busy  output  1  high in REQ or HOLD

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, irq_req=0, irq_vector=0, miss_count=0, irq_busy=0, last_flag=0.
- Sample valid:
  - export_valid = (counter_addition[DATA_WIDTH-1:1] == 1).
  - flag = counter_addition[0].
  - last_flag updates only on cycles where export_valid=1.
  - Cycles with export_valid=0 are ignored entirely: no event is generated and last_flag is held.
- Event (edge mode): event = export_valid && flag && !last_flag.
- FSM, registered, all transitions take effect on the next posedge clk:
  - IDLE:
    - event && irq_en -> REQ; irq_vector <= counter_result on the same edge.
    - event && !irq_en -> stay IDLE; the event is discarded and not counted as a miss.
  - REQ (irq_req=1):
    - irq_ack=1 -> HOLD.
    - irq_en=0 (and no ack) -> IDLE; the request is withdrawn and irq_vector is kept.
    - If irq_ack=1 and irq_en=0 in the same cycle, ack wins -> HOLD.
  - HOLD (irq_req=0, irq_busy=1):
    - irq_ack=0 -> IDLE.
    - Otherwise stay in HOLD.
- Latency:
  - Qualifying sample at edge N -> irq_req high after edge N, i.e. during cycle N+1.
  - A new event is accepted only in IDLE, so the minimum request-to-request spacing is 3 cycles.
- Miss counting:
  - An event while in REQ or HOLD increments miss_count, saturating at all-ones with no wrap.
  - miss_clr alone -> miss_count <= 0.
  - miss_clr together with a miss event in the same cycle -> miss_count <= 1.
- irq_busy = (state != IDLE), combinational from the state register.
- irq_vector changes only on an accepted event; it is stable while in REQ and HOLD.
- Reset asserted mid-handshake (REQ or HOLD):
  - Immediately returns to IDLE and drops irq_req.
  - The core must then treat its ack as spurious.

Optional Feature:
- Macro: COUNTER_IRQ_LEVEL_EN.
- Defined (level mode):
  - event = export_valid && flag; every valid sample with the flag high is an event.
  - last_flag is not implemented.
  - A flag held high while busy increments miss_count once per valid sample.
- Undefined: edge mode as described in Behaviour.

Test Plan:
- Edge trigger:
  - Stimulus: irq_en=1; counter_addition=8'h02 then 8'h03 with counter_result=8'h2A.
  - Required: irq_req=1 one cycle after the 8'h03 sample; irq_vector=8'h2A.
  - Then ack 1 -> irq_req=0; ack 0 -> back to IDLE.
- No retrigger on held flag:
  - Stimulus: 8'h03 held for 5 valid cycles; complete one handshake.
  - Required: exactly one request; miss_count=0 (edge mode).
- Miss saturation:
  - Stimulus: while in REQ, apply 20 rising edges of the flag (8'h02/8'h03 alternating); then miss_clr=1 in the same cycle as a further event.
  - Required: miss_count=4'hF after the edges; miss_count=1 after the clr/event cycle.
- Disable:
  - Stimulus: irq_en=0 during an event, then irq_en drops while in REQ.
  - Required: no request and miss_count unchanged for the first; irq_req=0 and IDLE on the next cycle for the second, with irq_vector retained.
- Invalid samples ignored:
  - Stimulus: counter_addition=8'h00 interleaved between 8'h03 samples.
  - Required: no new event, because last_flag holds across the invalid cycles.
- Async reset:
  - Stimulus: assert rst_n=0 mid-clock while in REQ.
  - Required: irq_req, irq_vector and miss_count reach 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/counter_irq_ctrl.sv
// rtl/counter_irq_ctrl.sv - counter stop-value interrupt with 4-phase req/ack and miss counting
// Define COUNTER_IRQ_LEVEL_EN for level-triggered events (default: rising-edge of the reach flag).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module counter_irq_ctrl #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int MISS_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] counter_result,
  input  logic [DATA_WIDTH-1:0] counter_addition,
  input  logic                  irq_en,
  input  logic                  irq_ack,
  input  logic                  miss_clr,
  output logic                  irq_req,
  output logic [DATA_WIDTH-1:0] irq_vector,
  output logic [MISS_WIDTH-1:0] miss_count,
  output logic                  irq_busy
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

  localparam logic [DATA_WIDTH-2:0] EXPORT_TAG = {{(DATA_WIDTH-2){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   vector_q, vector_d;
  logic [MISS_WIDTH-1:0]   miss_q, miss_d;
  logic                    export_valid;
  logic                    flag;
  logic                    evt;
  logic                    miss_evt;

  assign export_valid = (counter_addition[DATA_WIDTH-1:1] == EXPORT_TAG);
  assign flag         = counter_addition[0];

`ifdef COUNTER_IRQ_LEVEL_EN
  assign evt = export_valid && flag;
`else
  logic last_flag_q;

  // last_flag only tracks valid samples so invalid cycles cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_flag_q <= 1'b0;
    end else if (export_valid) begin
      last_flag_q <= flag;
    end
  end

  assign evt = export_valid && flag && !last_flag_q;
`endif

  assign miss_evt = evt && (state_q != IDLE);

  always_comb begin
    miss_d = miss_q;
    if (miss_clr) begin
      miss_d = miss_evt ? {{(MISS_WIDTH-1){1'b0}}, 1'b1} : '0;
    end else if (miss_evt && (miss_q != '1)) begin
      miss_d = miss_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    case (state_q)
      IDLE: begin
        if (evt && irq_en) begin
          state_d  = REQ;
          vector_d = counter_result;
        end
      end
      REQ: begin
        // Ack takes priority over a concurrent disable.
        if (irq_ack) begin
          state_d = HOLD;
        end else if (!irq_en) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (!irq_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vector_q <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      vector_q <= vector_d;
      miss_q   <= miss_d;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign irq_busy   = (state_q != IDLE);
  assign irq_vector = vector_q;
  assign miss_count = miss_q;

endmodule
